// File: rtl/foc_pkg.sv
// Shared types, constants and the symmetric saturation helper for the FOC PI scheduler.
package foc_pkg;

  localparam int unsigned N  = 10;
  localparam int unsigned F  = 9;
  localparam int unsigned WI = 2 * N + 2;

  localparam int OUT_MAX_I = (1 << (N - 1)) - 1;

  localparam logic signed [N-1:0]  OUT_MAX = N'(OUT_MAX_I);
  localparam logic signed [N-1:0]  OUT_MIN = N'(-OUT_MAX_I);
  localparam logic signed [WI-1:0] SAT_HI  = WI'(OUT_MAX_I);
  localparam logic signed [WI-1:0] SAT_LO  = WI'(-OUT_MAX_I);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPD_MUL,
    ST_SPD_ACC,
    ST_ID_MUL,
    ST_ID_ACC,
    ST_IQ_MUL,
    ST_IQ_ACC,
    ST_DONE
  } sched_state_e;

  typedef enum logic [1:0] {
    LOOP_SPEED,
    LOOP_ID,
    LOOP_IQ
  } loop_sel_e;

  // Clamp a wide intermediate to the symmetric output range.
  function automatic logic signed [N-1:0] sat_sym(input logic signed [WI-1:0] x);
    logic signed [N-1:0] r;
    if (x > SAT_HI) begin
      r = OUT_MAX;
    end else if (x < SAT_LO) begin
      r = OUT_MIN;
    end else begin
      r = x[N-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/foc_pi_core.sv
// Shared PI datapath: multiply stage registered into p/i_inc, then a combinational
// accumulate/saturate/back-calculation stage consumed by the scheduler.
module foc_pi_core
  import foc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mul_en_i,
  input  logic signed [N-1:0] ref_i,
  input  logic signed [N-1:0] meas_i,
  input  logic        [N-1:0] kp_i,
  input  logic        [N-1:0] ki_i,
  input  logic        [N-1:0] kaw_i,
  input  logic signed [N-1:0] integ_i,
  output logic signed [N-1:0] out_c_o,
  output logic signed [N-1:0] integ_c_o
);

  logic signed [WI-1:0] err_w, kp_w, ki_w, kaw_w;
  logic signed [WI-1:0] p_d, iinc_d, p_q, iinc_q;
  logic signed [WI-1:0] u_w, aw_w, integ_sum_w;
  logic signed [N-1:0]  out_w;

  always_comb begin
    kp_w   = WI'(kp_i);
    ki_w   = WI'(ki_i);
    kaw_w  = WI'(kaw_i);
    err_w  = WI'(ref_i) - WI'(meas_i);
    p_d    = (kp_w * err_w) >>> F;
    iinc_d = (ki_w * err_w) >>> F;
    // Output uses the integrator including this step's increment.
    u_w         = p_q + WI'(integ_i) + iinc_q;
    out_w       = sat_sym(u_w);
    aw_w        = (kaw_w * (WI'(out_w) - u_w)) >>> F;
    integ_sum_w = WI'(integ_i) + iinc_q + aw_w;
    out_c_o     = out_w;
    integ_c_o   = sat_sym(integ_sum_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      iinc_q <= '0;
    end else if (mul_en_i) begin
      p_q    <= p_d;
      iinc_q <= iinc_d;
    end
  end

endmodule

// File: rtl/foc_pi_scheduler.sv
// Runs speed -> id -> iq PI loops on one shared core per ctrl_tick.
// Optional FOC_SCHED_TORQUE_MODE_EN adds torque_mode/torque_ref to bypass the speed loop.
module foc_pi_scheduler
  import foc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ctrl_tick,
  input  logic                enable,
  input  logic                clear_overrun,
`ifdef FOC_SCHED_TORQUE_MODE_EN
  input  logic                torque_mode,
  input  logic signed [N-1:0] torque_ref,
`endif
  input  logic signed [N-1:0] speed_ref,
  input  logic signed [N-1:0] speed_meas,
  input  logic signed [N-1:0] id_ref,
  input  logic signed [N-1:0] i_d,
  input  logic signed [N-1:0] i_q,
  input  logic        [N-1:0] kp_speed,
  input  logic        [N-1:0] ki_speed,
  input  logic        [N-1:0] kaw_speed,
  input  logic        [N-1:0] kp_id,
  input  logic        [N-1:0] ki_id,
  input  logic        [N-1:0] kaw_id,
  input  logic        [N-1:0] kp_iq,
  input  logic        [N-1:0] ki_iq,
  input  logic        [N-1:0] kaw_iq,
  output logic signed [N-1:0] iq_ref,
  output logic signed [N-1:0] v_d,
  output logic signed [N-1:0] v_q,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  sched_state_e        state_q;
  loop_sel_e           loop_sel;
  logic                mul_en;
  logic signed [N-1:0] iq_ref_q, v_d_q, v_q_q;
  logic signed [N-1:0] integ_spd_q, integ_id_q, integ_iq_q;
  logic                busy_q, done_q, ovr_q;
  logic signed [N-1:0] ref_m, meas_m, integ_m;
  logic        [N-1:0] kp_m, ki_m, kaw_m;
  logic signed [N-1:0] core_out, core_integ;

  // Loop selection and operand muxing for the shared core.
  always_comb begin
    loop_sel = LOOP_SPEED;
    mul_en   = 1'b0;
    case (state_q)
      ST_SPD_MUL: mul_en = 1'b1;
      ST_ID_MUL:  begin loop_sel = LOOP_ID; mul_en = 1'b1; end
      ST_ID_ACC:  loop_sel = LOOP_ID;
      ST_IQ_MUL:  begin loop_sel = LOOP_IQ; mul_en = 1'b1; end
      ST_IQ_ACC:  loop_sel = LOOP_IQ;
      default:    ;
    endcase

    ref_m   = speed_ref;
    meas_m  = speed_meas;
    kp_m    = kp_speed;
    ki_m    = ki_speed;
    kaw_m   = kaw_speed;
    integ_m = integ_spd_q;
    case (loop_sel)
      LOOP_ID: begin
        ref_m = id_ref; meas_m = i_d; kp_m = kp_id; ki_m = ki_id; kaw_m = kaw_id;
        integ_m = integ_id_q;
      end
      LOOP_IQ: begin
        ref_m = iq_ref_q; meas_m = i_q; kp_m = kp_iq; ki_m = ki_iq; kaw_m = kaw_iq;
        integ_m = integ_iq_q;
      end
      default: ;
    endcase
  end

  foc_pi_core u_core (
    .clk      (clk),
    .rst      (rst),
    .mul_en_i (mul_en),
    .ref_i    (ref_m),
    .meas_i   (meas_m),
    .kp_i     (kp_m),
    .ki_i     (ki_m),
    .kaw_i    (kaw_m),
    .integ_i  (integ_m),
    .out_c_o  (core_out),
    .integ_c_o(core_integ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      iq_ref_q    <= '0;
      v_d_q       <= '0;
      v_q_q       <= '0;
      integ_spd_q <= '0;
      integ_id_q  <= '0;
      integ_iq_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A tick while busy sets overrun even if clear_overrun is also high.
      if ((state_q != ST_IDLE) && ctrl_tick) begin
        ovr_q <= 1'b1;
      end else if (clear_overrun) begin
        ovr_q <= 1'b0;
      end

      if (!enable) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        iq_ref_q    <= '0;
        v_d_q       <= '0;
        v_q_q       <= '0;
        integ_spd_q <= '0;
        integ_id_q  <= '0;
        integ_iq_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ctrl_tick) begin
              busy_q  <= 1'b1;
              state_q <= ST_SPD_MUL;
`ifdef FOC_SCHED_TORQUE_MODE_EN
              if (torque_mode) begin
                state_q     <= ST_ID_MUL;
                iq_ref_q    <= torque_ref;
                integ_spd_q <= '0;
              end
`endif
            end
          end
          ST_SPD_MUL: state_q <= ST_SPD_ACC;
          ST_SPD_ACC: begin
            iq_ref_q    <= core_out;
            integ_spd_q <= core_integ;
            state_q     <= ST_ID_MUL;
          end
          ST_ID_MUL:  state_q <= ST_ID_ACC;
          ST_ID_ACC: begin
            v_d_q      <= core_out;
            integ_id_q <= core_integ;
            state_q    <= ST_IQ_MUL;
          end
          ST_IQ_MUL:  state_q <= ST_IQ_ACC;
          ST_IQ_ACC: begin
            v_q_q      <= core_out;
            integ_iq_q <= core_integ;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end
          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign iq_ref  = iq_ref_q;
  assign v_d     = v_d_q;
  assign v_q     = v_q_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_foc_pi_scheduler.sv
// Self-checking bench for foc_pi_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a cycle-offset behavioural model.
module tb_foc_pi_scheduler;

  localparam int NW = 10;

  logic clk = 1'b0;
  logic rst, ctrl_tick, enable, clear_overrun;
  logic signed [NW-1:0] speed_ref, speed_meas, id_ref, i_d, i_q;
  logic [NW-1:0] kp_speed, ki_speed, kaw_speed, kp_id, ki_id, kaw_id, kp_iq, ki_iq, kaw_iq;
  logic signed [NW-1:0] iq_ref, v_d, v_q;
  logic busy, done, overrun;
`ifdef FOC_SCHED_TORQUE_MODE_EN
  logic torque_mode = 1'b0;
  logic signed [NW-1:0] torque_ref = '0;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: position within a sequence (0 = idle, k = k cycles after the tick).
  int m_pos = 0, m_iq = 0, m_vd = 0, m_vq = 0, m_p = 0, m_ii = 0, m_ovr = 0, m_done = 0;
  int m_int [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  foc_pi_scheduler dut (
    .clk(clk), .rst(rst), .ctrl_tick(ctrl_tick), .enable(enable), .clear_overrun(clear_overrun),
`ifdef FOC_SCHED_TORQUE_MODE_EN
    .torque_mode(torque_mode), .torque_ref(torque_ref),
`endif
    .speed_ref(speed_ref), .speed_meas(speed_meas), .id_ref(id_ref), .i_d(i_d), .i_q(i_q),
    .kp_speed(kp_speed), .ki_speed(ki_speed), .kaw_speed(kaw_speed),
    .kp_id(kp_id), .ki_id(ki_id), .kaw_id(kaw_id),
    .kp_iq(kp_iq), .ki_iq(ki_iq), .kaw_iq(kaw_iq),
    .iq_ref(iq_ref), .v_d(v_d), .v_q(v_q), .busy(busy), .done(done), .overrun(overrun)
  );

  function automatic int sat(input int x);
    if (x > 511) return 511;
    if (x < -511) return -511;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_iq = 0; m_vd = 0; m_vq = 0;
    m_int[0] = 0; m_int[1] = 0; m_int[2] = 0;
  endtask

  task automatic m_mul(input int r, input int m, input int kp, input int ki);
    m_p  = (kp * (r - m)) >>> 9;
    m_ii = (ki * (r - m)) >>> 9;
  endtask

  task automatic m_acc(input int k, input int kaw, output int out);
    int u;
    u   = m_p + m_int[k] + m_ii;
    out = sat(u);
    m_int[k] = sat(m_int[k] + m_ii + ((kaw * (out - u)) >>> 9));
  endtask

  // Behavioural reference, advanced on every rising edge from the same sampled inputs.
  always @(posedge clk) begin
    m_done = 0;
    if (rst) begin
      m_pos = 0; m_ovr = 0;
      m_clear();
    end else begin
      if (m_pos != 0 && ctrl_tick) m_ovr = 1;
      else if (clear_overrun) m_ovr = 0;
      if (!enable) begin
        m_pos = 0;
        m_clear();
      end else if (m_pos == 0) begin
        if (ctrl_tick) m_pos = 1;
      end else begin
        case (m_pos)
          1: m_mul(int'(speed_ref), int'(speed_meas), int'(kp_speed), int'(ki_speed));
          2: m_acc(0, int'(kaw_speed), m_iq);
          3: m_mul(int'(id_ref), int'(i_d), int'(kp_id), int'(ki_id));
          4: m_acc(1, int'(kaw_id), m_vd);
          5: m_mul(m_iq, int'(i_q), int'(kp_iq), int'(ki_iq));
          6: begin m_acc(2, int'(kaw_iq), m_vq); m_done = 1; end
          default: ;
        endcase
        m_pos = (m_pos == 7) ? 0 : m_pos + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_iq_ref", int'(iq_ref), m_iq);
      chk("cyc_v_d", int'(v_d), m_vd);
      chk("cyc_v_q", int'(v_q), m_vq);
      chk("cyc_busy", int'(busy), (m_pos != 0) ? 1 : 0);
      chk("cyc_done", int'(done), m_done);
      chk("cyc_overrun", int'(overrun), m_ovr);
    end
  end

  // Issue one tick and return the cycle in which done appeared (-1 on timeout).
  task automatic run_seq(output int lat);
    lat = -1;
    ctrl_tick = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      ctrl_tick = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int lat, ndone, dcyc;
    rst = 1'b1; ctrl_tick = 1'b0; enable = 1'b0; clear_overrun = 1'b0;
    speed_ref = '0; speed_meas = '0; id_ref = '0; i_d = '0; i_q = '0;
    kp_speed = '0; ki_speed = '0; kaw_speed = '0; kp_id = '0; ki_id = '0; kaw_id = '0;
    kp_iq = '0; ki_iq = '0; kaw_iq = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    chk("reset_iq_ref", int'(iq_ref), 0);
    chk("reset_busy", int'(busy), 0);

    // Proportional only through speed then iq loop.
    enable = 1'b1; kp_speed = 10'd256; kp_iq = 10'd256; speed_ref = 10'sd200;
    run_seq(lat);
    chk("p_latency", lat, 7);
    chk("p_iq_ref", int'(iq_ref), 100);
    chk("p_v_q", int'(v_q), 50);
    chk("p_v_d", int'(v_d), 0);

    // Extreme error saturates without wrap.
    kp_speed = 10'd511; speed_ref = 10'sd511; speed_meas = -10'sd512;
    run_seq(lat);
    chk("sat_iq_ref", int'(iq_ref), 511);
    chk("sat_v_q", int'(v_q), 255);

    // Pure integral on the d loop.
    kp_speed = '0; speed_ref = '0; speed_meas = '0; ki_id = 10'd64; id_ref = 10'sd80;
    for (int k = 1; k <= 5; k++) begin
      run_seq(lat);
      chk("int_v_d", int'(v_d), 10 * k);
      chk("int_model_v_d", m_vd, 10 * k);
    end

    // Second tick at cycle 3 is ignored and flags overrun.
    ndone = 0; dcyc = -1;
    ctrl_tick = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      ctrl_tick = (i == 3);
      if (done) begin ndone++; dcyc = i; end
    end
    chk("ovr_done_count", ndone, 1);
    chk("ovr_done_cycle", dcyc, 7);
    chk("ovr_set", int'(overrun), 1);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    chk("ovr_cleared", int'(overrun), 0);

    // Enable dropped in cycle 4 aborts the sequence and clears state.
    ndone = 0;
    ctrl_tick = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      ctrl_tick = 1'b0;
      if (done) ndone++;
      if (i == 4) enable = 1'b0;
    end
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_v_d", int'(v_d), 0);
    chk("abort_iq_ref", int'(iq_ref), 0);
    for (int i = 6; i <= 9; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    enable = 1'b1;
    @(negedge clk);
    run_seq(lat);
    chk("abort_integ_cleared", int'(v_d), 10);

    // Reset held two cycles mid-sequence with overrun pending.
    ctrl_tick = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      ctrl_tick = (i == 2);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_iq_ref", int'(iq_ref), 0);
    chk("rst_v_d", int'(v_d), 0);
    chk("rst_v_q", int'(v_q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      rst           = ($urandom_range(999) == 0);
      ctrl_tick     = ($urandom_range(5) == 0);
      enable        = ($urandom_range(59) != 0);
      clear_overrun = ($urandom_range(19) == 0);
      if ($urandom_range(3) == 0) begin
        speed_ref  = NW'($urandom_range(1023));
        speed_meas = NW'($urandom_range(1023));
        id_ref     = NW'($urandom_range(1023));
        i_d        = NW'($urandom_range(1023));
        i_q        = NW'($urandom_range(1023));
      end
      if ($urandom_range(15) == 0) begin
        kp_speed = NW'($urandom_range(511)); ki_speed = NW'($urandom_range(127));
        kaw_speed = NW'($urandom_range(511));
        kp_id = NW'($urandom_range(511)); ki_id = NW'($urandom_range(127));
        kaw_id = NW'($urandom_range(511));
        kp_iq = NW'($urandom_range(511)); ki_iq = NW'($urandom_range(127));
        kaw_iq = NW'($urandom_range(511));
      end
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
